// File: rtl/axis_dest_router.sv
// 1-to-NUM_OUT AXI4-Stream router: decodes TDEST on the packet head, locks the route until
// TLAST, holds each beat in a one-entry output register, and discards/counts unmapped packets.
module axis_dest_router #(
  parameter int unsigned NUM_OUT   = 4,
  parameter logic [4:0]  BASE_DEST = 5'd1,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                i_sclk,
  input  logic                i_srst,
  input  logic                i_s_tvalid,
  input  logic [DATA_W-1:0]   i_s_tdata,
  input  logic [4:0]          i_s_tdest,
  input  logic                i_s_tlast,
  output logic                o_s_tready,
  output logic [NUM_OUT-1:0]  o_m_tvalid,
  output logic [DATA_W-1:0]   o_m_tdata,
  output logic [4:0]          o_m_tdest,
  output logic                o_m_tlast,
  input  logic [NUM_OUT-1:0]  i_m_tready,
  output logic [7:0]          o_drop_cnt,
  output logic                o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_out_v;
  logic [2:0]        r_out_sel;
  logic [DATA_W-1:0] r_data;
  logic [4:0]        r_dest;
  logic              r_last;
  logic [7:0]        r_drop_cnt;

  logic [5:0] w_k;
  logic       w_mapped, w_deliver, w_ready, w_accept;
  logic       w_load, w_head, w_drop_inc;

  // Underflow of the 6-bit subtraction sets bit 5, so it always fails the range test.
  assign w_k      = {1'b0, i_s_tdest} - {1'b0, BASE_DEST};
  assign w_mapped = (w_k < 6'(NUM_OUT));

  always_comb begin
    o_m_tvalid = '0;
    if (r_out_v) o_m_tvalid = NUM_OUT'(1) << r_out_sel;
  end

  assign w_deliver  = |(o_m_tvalid & i_m_tready);
  assign w_ready    = (r_state == S_DROP) | ~r_out_v | w_deliver;
  assign o_s_tready = w_ready & ~i_srst;
  assign w_accept   = i_s_tvalid & o_s_tready;

  always_ff @(posedge i_sclk or posedge i_srst) begin
    if (i_srst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_head      = 1'b0;
    w_drop_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_mapped) begin
            w_load = 1'b1;
            w_head = 1'b1;
            if (!i_s_tlast) w_state_nxt = S_FWD;
          end else if (i_s_tlast) begin
            w_drop_inc = 1'b1;
          end else begin
            w_state_nxt = S_DROP;
          end
        end
      end
      S_FWD: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (i_s_tlast) w_state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (w_accept && i_s_tlast) begin
          w_drop_inc  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Route and head TDEST are only captured on the head beat; body beats reuse them.
  always_ff @(posedge i_sclk or posedge i_srst) begin
    if (i_srst) begin
      r_out_v    <= 1'b0;
      r_out_sel  <= '0;
      r_data     <= '0;
      r_dest     <= '0;
      r_last     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_load) begin
        r_out_v <= 1'b1;
        r_data  <= i_s_tdata;
        r_last  <= i_s_tlast;
        if (w_head) begin
          r_out_sel <= w_k[2:0];
          r_dest    <= i_s_tdest;
        end
      end else if (w_deliver) begin
        r_out_v <= 1'b0;
      end
      if (w_drop_inc && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign o_m_tdata  = r_data;
  assign o_m_tdest  = r_dest;
  assign o_m_tlast  = r_last;
  assign o_drop_cnt = r_drop_cnt;
  assign o_busy     = (r_state != S_IDLE) | r_out_v;

endmodule
